// File: rtl/key_event_if.sv
// Key event decoder bus: raw/debounced key inputs and the decoded event outputs.
interface key_event_if;
  logic key;
  logic key_flag;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_busy;

  modport master (
    output key, key_flag,
    input  short_pulse, double_pulse, long_pulse, repeat_pulse, key_busy
  );

  modport slave (
    input  key, key_flag,
    output short_pulse, double_pulse, long_pulse, repeat_pulse, key_busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key presses into single, double, long-press and auto-repeat events.
// Define KEY_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module key_event_decoder #(
  parameter int unsigned LONG_CNT    = 50_000_000,
  parameter int unsigned DBL_CNT     = 15_000_000,
  parameter int unsigned REPEAT_CNT  = 10_000_000,
  parameter int unsigned RELEASE_CNT = 1_000_000
) (
  input logic        sys_clk,
  input logic        sys_rst_n,
  key_event_if.slave key_if
);

  localparam int unsigned TmrMaxA = (LONG_CNT > DBL_CNT) ? LONG_CNT : DBL_CNT;
  localparam int unsigned TmrMax  = (TmrMaxA > REPEAT_CNT) ? TmrMaxA : REPEAT_CNT;
  localparam int unsigned TmrW    = (TmrMax > 2) ? $clog2(TmrMax) : 1;
  localparam int unsigned RelW    = (RELEASE_CNT > 2) ? $clog2(RELEASE_CNT) : 1;

  localparam logic [TmrW-1:0] LongEnd = TmrW'(LONG_CNT - 1);
  localparam logic [TmrW-1:0] DblEnd  = TmrW'(DBL_CNT - 1);
  localparam logic [RelW-1:0] RelEnd  = RelW'(RELEASE_CNT - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [TmrW-1:0] RepEnd  = TmrW'(REPEAT_CNT - 1);
`endif

  typedef enum logic [2:0] {StIdle, StHold1, StWait2, StHold2, StLong} state_e;

  state_e          r_state, w_state_d;
  logic [TmrW-1:0] r_tmr, w_tmr_d;
  logic [RelW-1:0] r_rel_cnt;
  logic            r_key_meta, r_key_s;
  logic            w_rel_done;
  logic            r_short, r_double, r_long;
  logic            w_short_d, w_double_d, w_long_d;

  // Raw key is asynchronous; idle (released) level is high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_meta <= 1'b1;
      r_key_s    <= 1'b1;
    end else begin
      r_key_meta <= key_if.key;
      r_key_s    <= r_key_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rel_cnt <= '0;
    end else if (!r_key_s) begin
      r_rel_cnt <= '0;
    end else if (!w_rel_done) begin
      r_rel_cnt <= r_rel_cnt + 1'b1;
    end
  end

  assign w_rel_done = (r_rel_cnt == RelEnd);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= StIdle;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_tmr   <= w_tmr_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (key_if.key_flag) w_state_d = StHold1;
      StHold1: begin
        if (r_tmr == LongEnd)  w_state_d = StLong;
        else if (w_rel_done)   w_state_d = StWait2;
      end
      StWait2: begin
        if (key_if.key_flag)   w_state_d = StHold2;
        else if (r_tmr == DblEnd) w_state_d = StIdle;
      end
      StHold2: if (w_rel_done) w_state_d = StIdle;
      StLong:  if (w_rel_done) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Shared timer restarts on every state change; idle states hold it at zero.
  always_comb begin
    w_tmr_d = '0;
    if (w_state_d == r_state) begin
      unique case (r_state)
        StHold1, StWait2: w_tmr_d = r_tmr + 1'b1;
`ifdef KEY_REPEAT_EN
        StLong:           w_tmr_d = (r_tmr == RepEnd) ? '0 : r_tmr + 1'b1;
`endif
        default:          w_tmr_d = '0;
      endcase
    end
  end

  always_comb begin
    w_short_d  = (r_state == StWait2) && !key_if.key_flag && (r_tmr == DblEnd);
    w_double_d = (r_state == StHold2) && w_rel_done;
    w_long_d   = (r_state == StHold1) && (r_tmr == LongEnd);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_short  <= w_short_d;
      r_double <= w_double_d;
      r_long   <= w_long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  logic r_repeat;
  logic w_repeat_d;

  assign w_repeat_d = (r_state == StLong) && !w_rel_done && (r_tmr == RepEnd);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_repeat <= 1'b0;
    else            r_repeat <= w_repeat_d;
  end

  assign key_if.repeat_pulse = r_repeat;
`else
  assign key_if.repeat_pulse = 1'b0;
`endif

  assign key_if.short_pulse  = r_short;
  assign key_if.double_pulse = r_double;
  assign key_if.long_pulse   = r_long;
  assign key_if.key_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed bench for key_event_decoder against a behavioural event model.
module tb_key_event_decoder;

  localparam int unsigned LongCnt = 100;
  localparam int unsigned DblCnt  = 30;
  localparam int unsigned RepCnt  = 20;
  localparam int unsigned RelCnt  = 5;

  localparam int PhIdle  = 0;
  localparam int PhHold1 = 1;
  localparam int PhWait2 = 2;
  localparam int PhHold2 = 3;
  localparam int PhLong  = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  key_event_if kif ();

  key_event_decoder #(
    .LONG_CNT   (LongCnt),
    .DBL_CNT    (DblCnt),
    .REPEAT_CNT (RepCnt),
    .RELEASE_CNT(RelCnt)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_if   (kif)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_short, cnt_double, cnt_long, cnt_repeat;

  // Reference model state: synchronizer history, run of high samples, phase and time in phase.
  logic m_meta, m_s;
  int   m_high_run;
  int   m_phase;
  int   m_elapsed;
  int   e_short, e_double, e_long, e_repeat;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_meta = 1'b1; m_s = 1'b1; m_high_run = 0;
    m_phase = PhIdle; m_elapsed = 0;
    e_short = 0; e_double = 0; e_long = 0; e_repeat = 0;
  endtask

  task automatic model_step(input logic k, input logic f);
    bit released;
    int nxt;
    released = (m_high_run >= int'(RelCnt) - 1);
    nxt = m_phase;
    e_short = 0; e_double = 0; e_long = 0; e_repeat = 0;
    case (m_phase)
      PhIdle:  if (f) nxt = PhHold1;
      PhHold1: begin
        if (m_elapsed == int'(LongCnt) - 1) begin nxt = PhLong; e_long = 1; end
        else if (released) nxt = PhWait2;
      end
      PhWait2: begin
        if (f) nxt = PhHold2;
        else if (m_elapsed == int'(DblCnt) - 1) begin nxt = PhIdle; e_short = 1; end
      end
      PhHold2: if (released) begin nxt = PhIdle; e_double = 1; end
      PhLong: begin
        if (released) nxt = PhIdle;
`ifdef KEY_REPEAT_EN
        else if (m_elapsed % int'(RepCnt) == int'(RepCnt) - 1) e_repeat = 1;
`endif
      end
      default: nxt = PhIdle;
    endcase
    m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
    m_phase = nxt;
    if (m_s) m_high_run = (m_high_run < int'(RelCnt) - 1) ? m_high_run + 1 : m_high_run;
    else     m_high_run = 0;
    m_s    = m_meta;
    m_meta = k;
  endtask

  task automatic clr_cnt();
    cnt_short = 0; cnt_double = 0; cnt_long = 0; cnt_repeat = 0;
  endtask

  task automatic cycle(input logic k, input logic f);
    kif.key = k;
    kif.key_flag = f;
    @(posedge sys_clk);
    model_step(k, f);
    #1;
    check("short_pulse",  int'(kif.short_pulse),  e_short);
    check("double_pulse", int'(kif.double_pulse), e_double);
    check("long_pulse",   int'(kif.long_pulse),   e_long);
    check("repeat_pulse", int'(kif.repeat_pulse), e_repeat);
    check("key_busy",     int'(kif.key_busy),     int'(m_phase != PhIdle));
    check("one_event", int'($countones({kif.short_pulse, kif.double_pulse, kif.long_pulse,
                                         kif.repeat_pulse}) <= 1), 1);
    cnt_short  += int'(kif.short_pulse);
    cnt_double += int'(kif.double_pulse);
    cnt_long   += int'(kif.long_pulse);
    cnt_repeat += int'(kif.repeat_pulse);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0);
  endtask

  // Key goes low, filter flags the press two cycles later; hold counts from the flag.
  task automatic press(input int hold);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (hold - 1) cycle(1'b0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_short"},  int'(kif.short_pulse),  0);
    check({tag, "_double"}, int'(kif.double_pulse), 0);
    check({tag, "_long"},   int'(kif.long_pulse),   0);
    check({tag, "_repeat"}, int'(kif.repeat_pulse), 0);
    check({tag, "_busy"},   int'(kif.key_busy),     0);
  endtask

  task automatic pulse_reset();
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    model_reset();
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    kif.key = 1'b1;
    kif.key_flag = 1'b0;
    model_reset();
    clr_cnt();
    #1;
    check_outputs_zero("por");
    #21;
    sys_rst_n = 1'b1;
    idle(5);

    // Single click
    clr_cnt();
    press(10); idle(60);
    check("single_short_cnt", cnt_short, 1);
    check("single_double_cnt", cnt_double, 0);
    check("single_busy_end", int'(kif.key_busy), 0);

    // Double click
    clr_cnt();
    press(10); idle(17); press(10); idle(20);
    check("double_cnt", cnt_double, 1);
    check("double_short_cnt", cnt_short, 0);

    // Second press lands on the WAIT2 expiry cycle
    clr_cnt();
    press(10);
    guard = 0;
    while (!(m_phase == PhWait2 && m_elapsed == int'(DblCnt) - 5) && guard < 200) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check("w2_reach", int'(guard < 200), 1);
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0);
    idle(20);
    check("tie_short_cnt", cnt_short, 0);
    check("tie_double_cnt", cnt_double, 1);

    // Long hold with optional auto-repeat
    clr_cnt();
    press(165); idle(40);
    check("long_cnt", cnt_long, 1);
`ifdef KEY_REPEAT_EN
    check("repeat_cnt", cnt_repeat, 3);
`else
    check("repeat_cnt", cnt_repeat, 0);
`endif
    check("long_short_cnt", cnt_short, 0);

    // Short glitch high during HOLD1 is not a release
    clr_cnt();
    press(20);
    repeat (3) cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);
    idle(60);
    check("glitch_short_cnt", cnt_short, 1);

    // Reset during WAIT2 discards the pending click
    clr_cnt();
    press(10); idle(15);
    pulse_reset();
    idle(60);
    check("rst_short_cnt", cnt_short, 0);

    // Random traffic
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 5))
        0, 1: press(int'($urandom_range(1, 130)));
        2:    idle(int'($urandom_range(0, 45)));
        3: begin
          repeat ($urandom_range(1, 6)) cycle(1'b1, 1'b0);
          repeat ($urandom_range(1, 10)) cycle(1'b0, 1'b0);
        end
        4: repeat ($urandom_range(1, 20))
             cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        default: begin
          if ($urandom_range(0, 9) == 0) pulse_reset();
          else idle(int'($urandom_range(30, 50)));
        end
      endcase
    end
    idle(200);
    check("final_busy", int'(kif.key_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CNT, 50_000_000, hold cycles before a long press (1 s at 50 MHz).
REQ-002 Parameter DBL_CNT, 15_000_000, max gap cycles between release and second press for a double click (300 ms).
REQ-003 Parameter REPEAT_CNT, 10_000_000, auto-repeat period in cycles during a long hold (200 ms).
REQ-004 Parameter RELEASE_CNT, 1_000_000, cycles key must stay high to confirm release (20 ms).
REQ-005 sys_clk  input  1  system clock, all logic on rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key  input  1  raw key level, active-low, asynchronous to sys_clk.
REQ-008 key_flag  input  1  one-cycle debounced-press pulse from the key filter.
REQ-009 short_pulse  output  1  one-cycle single-click event.
REQ-010 double_pulse  output  1  one-cycle double-click event.
REQ-011 long_pulse  output  1  one-cycle long-press start event.
REQ-012 repeat_pulse  output  1  one-cycle auto-repeat event during long hold.
REQ-013 key_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 key SHALL pass through a two-flop synchronizer; all decisions use the synchronized level key_s.
REQ-015 Release counter rel_cnt SHALL increment while key_s==1, saturate at RELEASE_CNT-1, clear to 0 while key_s==0; release confirmed when rel_cnt==RELEASE_CNT-1.
REQ-016 States: IDLE, HOLD1, WAIT2, HOLD2, LONG; one shared timer tmr, cleared on every state change.
REQ-017 IDLE: key_flag -> HOLD1; other inputs ignored.
REQ-018 HOLD1: tmr==LONG_CNT-1 -> LONG with long_pulse; else release confirmed -> WAIT2; long check has priority when both hold.
REQ-019 WAIT2: key_flag -> HOLD2; else tmr==DBL_CNT-1 -> IDLE with short_pulse; key_flag wins when both occur in the same cycle.
REQ-020 HOLD2: release confirmed -> IDLE with double_pulse; no long detection in HOLD2.
REQ-021 LONG: release confirmed -> IDLE, no event pulse; repeat behaviour per REQ-027/028.
REQ-022 key_flag outside IDLE and WAIT2 SHALL be ignored.
REQ-023 All event outputs registered, high exactly one cycle, asserted in the cycle after the triggering condition; at most one event output high in any cycle.
REQ-024 tmr and rel_cnt widths SHALL cover their largest parameter; no wrap-around before the terminal compare.

Reset
REQ-025 On sys_rst_n low: state IDLE, tmr 0, rel_cnt 0, synchronizer flops 1 (released), all outputs 0, effective immediately and asynchronously.
REQ-026 Reset asserted mid-sequence SHALL discard the sequence with no event emitted after deassertion.

Configuration
REQ-027 Macro KEY_REPEAT_EN defined: in LONG, tmr counts to REPEAT_CNT-1, emits repeat_pulse, restarts at 0, repeating until release.
REQ-028 KEY_REPEAT_EN undefined: repeat_pulse tied 0, no repeat timer logic; LONG only waits for release.

Verification (LONG_CNT=100, DBL_CNT=30, REPEAT_CNT=20, RELEASE_CNT=5)
REQ-029 key_flag, hold key low 10 cycles, release, no further press -> exactly one short_pulse after ~5+30 cycles, key_busy low afterwards.
REQ-030 press 10 cycles, release, key_flag 10 cycles after confirmed release, release -> one double_pulse, no short_pulse.
REQ-031 key_flag on the same cycle WAIT2 timer expires -> HOLD2 entered, no short_pulse, later double_pulse.
REQ-032 hold 165 cycles with KEY_REPEAT_EN -> long_pulse once, then 3 repeat_pulse spaced 20 cycles, none after release; without macro -> long_pulse only.
REQ-033 key glitch high 3 cycles during HOLD1 -> no release, state stays HOLD1.
REQ-034 sys_rst_n pulsed low in WAIT2 -> all outputs 0, IDLE, no short_pulse after reset release.
